// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 frames with a one-deep holding register and run-time baud select.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit(s).

// Per-bit clock counts for a 50 MHz clock; param.v supplies these when present.
`ifndef BAUD_9600
`define BAUD_9600 13'd5208
`endif
`ifndef BAUD_19200
`define BAUD_19200 13'd2604
`endif
`ifndef BAUD_38400
`define BAUD_38400 13'd1302
`endif
`ifndef BAUD_115200
`define BAUD_115200 13'd434
`endif

module uart_tx #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] baud_sel,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_vld,
    output logic       tx_rdy,
    output logic       tx_busy,
    output logic       tx_dout
);

`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME = 9 + PAR_BITS + STOP_BITS;
    localparam logic [3:0] LAST_BIT = 4'(FRAME - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            r_state;
    logic [7:0]        r_hold;
    logic              r_hold_full;
    logic [FRAME-1:0]  r_shift;
    logic [12:0]       r_baud;
    logic [12:0]       r_cnt_baud;
    logic [3:0]        r_cnt_bit;
    logic              r_busy;

    logic [12:0]       w_baud_cnt;
    logic [FRAME-1:0]  w_frame;
    logic              w_accept;
    logic              w_bit_end;
    logic              w_frame_end;
    logic              w_load;

    always_comb begin
        w_baud_cnt = `BAUD_9600;
        case (baud_sel)
            2'd1:    w_baud_cnt = `BAUD_19200;
            2'd2:    w_baud_cnt = `BAUD_38400;
            2'd3:    w_baud_cnt = `BAUD_115200;
            default: w_baud_cnt = `BAUD_9600;
        endcase
    end

    // Frame image is sent LSB first: start bit in bit 0, stop bits at the top.
`ifdef UART_TX_PARITY_EN
    assign w_frame = {{STOP_BITS{1'b1}}, ^r_hold, r_hold, 1'b0};
`else
    assign w_frame = {{STOP_BITS{1'b1}}, r_hold, 1'b0};
`endif

    assign w_accept    = tx_byte_vld && !r_hold_full;
    assign w_bit_end   = (r_cnt_baud == r_baud - 13'd1);
    assign w_frame_end = (r_state == SHIFT) && w_bit_end && (r_cnt_bit == LAST_BIT);
    // Accept needs an empty holding register and load needs a full one, so they never coincide.
    assign w_load      = r_hold_full && ((r_state == IDLE) || w_frame_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold      <= 8'd0;
            r_hold_full <= 1'b0;
            r_shift     <= '1;
            r_baud      <= 13'd0;
            r_cnt_baud  <= 13'd0;
            r_cnt_bit   <= 4'd0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= tx_byte;
                r_hold_full <= 1'b1;
            end
            if (w_load) begin
                r_state     <= SHIFT;
                r_shift     <= w_frame;
                r_baud      <= w_baud_cnt;
                r_cnt_baud  <= 13'd0;
                r_cnt_bit   <= 4'd0;
                r_busy      <= 1'b1;
                r_hold_full <= 1'b0;
            end else if (r_state == SHIFT) begin
                if (!w_bit_end) begin
                    r_cnt_baud <= r_cnt_baud + 13'd1;
                end else if (r_cnt_bit == LAST_BIT) begin
                    r_state    <= IDLE;
                    r_shift    <= '1;
                    r_cnt_baud <= 13'd0;
                    r_cnt_bit  <= 4'd0;
                    r_busy     <= 1'b0;
                end else begin
                    r_shift    <= {1'b1, r_shift[FRAME-1:1]};
                    r_cnt_baud <= 13'd0;
                    r_cnt_bit  <= r_cnt_bit + 4'd1;
                end
            end
        end
    end

    assign tx_rdy  = !r_hold_full;
    assign tx_busy = r_busy;
    assign tx_dout = r_shift[0];

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: writes push expected frames, a line monitor decodes and checks them.
// Build with UART_TX_PARITY_EN defined to exercise the parity frames as well.

module tb_uart_tx;

    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 10 + STOP_BITS;
`else
    localparam int FRAME = 9 + STOP_BITS;
`endif
    localparam int BAUD_FAST = 434;
    localparam int BAUD_SLOW = 5208;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] baud_sel = 2'd3;
    logic [7:0] tx_byte = 8'd0;
    logic       tx_byte_vld = 1'b0;
    logic       tx_rdy;
    logic       tx_busy;
    logic       tx_dout;

    typedef struct {
        logic [7:0] data;
        int         baud;
        int         maxGap;
    } expT;

    expT expQ[$];
    int  errors = 0;
    int  checks = 0;
    int  framesSeen = 0;
    int  framesExpected = 0;
    int  idleCount = 0;
    int  busyCount = 0;
    int  badCount = 0;
    bit  monEnable = 1'b0;
    bit  monBusy = 1'b0;

    uart_tx #(.STOP_BITS(STOP_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_sel   (baud_sel),
        .tx_byte    (tx_byte),
        .tx_byte_vld(tx_byte_vld),
        .tx_rdy     (tx_rdy),
        .tx_busy    (tx_busy),
        .tx_dout    (tx_dout)
    );

    always #5 clk = ~clk;

    function automatic logic frameBit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int baud, input int maxGap,
                                 input bit expectAccept, input bit track);
        expT e;
        @(negedge clk);
        checkOutput($sformatf("tx_rdy at write 0x%02h", d), int'(tx_rdy), int'(expectAccept));
        tx_byte     = d;
        tx_byte_vld = 1'b1;
        if (expectAccept && track) begin
            e.data   = d;
            e.baud   = baud;
            e.maxGap = maxGap;
            expQ.push_back(e);
            framesExpected++;
        end
        @(negedge clk);
        tx_byte_vld = 1'b0;
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n = 0;
        while ((expQ.size() != 0 || monBusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0 || monBusy) begin
            errors++;
            $display("[TB] FAIL %s drain: %0d frames still pending after %0d cycles", name, expQ.size(), budget);
        end
        repeat (20) @(negedge clk);
    endtask

    // Line monitor: every falling start bit consumes one expected frame and checks each sample of it.
    initial begin : monitor
        expT e;
        int  bad;
        forever begin
            @(negedge clk);
            if (!monEnable) begin
                idleCount = 0;
            end else if (tx_dout === 1'b1) begin
                idleCount++;
            end else begin
                monBusy = 1'b1;
                framesSeen++;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected frame %0d: start bit seen, no frame queued", framesSeen);
                    e.data   = 8'h00;
                    e.baud   = BAUD_FAST;
                    e.maxGap = -1;
                end else begin
                    e = expQ.pop_front();
                end
                if (e.maxGap >= 0) begin
                    checks++;
                    if (idleCount > e.maxGap) begin
                        errors++;
                        $display("[TB] FAIL gap before frame %0d: idle %0d cycles, allowed %0d",
                                 framesSeen, idleCount, e.maxGap);
                    end
                end
                for (int b = 0; b < FRAME; b++) begin
                    bad = 0;
                    for (int k = 0; k < e.baud; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (tx_dout !== frameBit(e.data, b) || tx_busy !== 1'b1) bad++;
                    end
                    checkOutput($sformatf("frame %0d (0x%02h) bit %0d bad samples", framesSeen, e.data, b), bad, 0);
                end
                idleCount = 0;
                monBusy   = 1'b0;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        baud_sel = 2'd3;
        repeat (3) @(negedge clk);
        checkOutput("reset tx_dout", int'(tx_dout), 1);
        checkOutput("reset tx_busy", int'(tx_busy), 0);
        checkOutput("reset tx_rdy", int'(tx_rdy), 1);
        rst_n     = 1'b1;
        monEnable = 1'b1;
        @(negedge clk);
        checkOutput("idle tx_dout after reset", int'(tx_dout), 1);

        // Basic 0xA5 frame and tx_busy width
        applyStimulus(8'hA5, BAUD_FAST, -1, 1'b1, 1'b1);
        busyCount = 0;
        for (int i = 0; i < FRAME * BAUD_FAST + 1000; i++) begin
            @(negedge clk);
            if (tx_busy) busyCount++;
            else if (busyCount > 0) break;
        end
        checkOutput("basic tx_busy high cycles", busyCount, FRAME * BAUD_FAST);
        checkOutput("basic tx_dout idle after frame", int'(tx_dout), 1);
        waitDrain(2000, "basic");

        // Back-to-back with a rejected third write
        applyStimulus(8'h55, BAUD_FAST, -1, 1'b1, 1'b1);
        repeat (1000) @(negedge clk);
        applyStimulus(8'h0F, BAUD_FAST, 0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        applyStimulus(8'h99, BAUD_FAST, -1, 1'b0, 1'b1);
        waitDrain(3 * FRAME * BAUD_FAST, "back-to-back");

        // Baud change mid-frame applies only to the queued frame
        baud_sel = 2'd0;
        applyStimulus(8'h00, BAUD_SLOW, -1, 1'b1, 1'b1);
        repeat (100) @(negedge clk);
        applyStimulus(8'h3C, BAUD_FAST, 0, 1'b1, 1'b1);
        repeat (2000) @(negedge clk);
        baud_sel = 2'd3;
        waitDrain(FRAME * (BAUD_SLOW + BAUD_FAST) + 1000, "baud change");

        // Write lands on the last stop-bit cycle of the previous frame
        applyStimulus(8'h7E, BAUD_FAST, -1, 1'b1, 1'b1);
        repeat (FRAME * BAUD_FAST - 1) @(negedge clk);
        applyStimulus(8'h81, BAUD_FAST, 1, 1'b1, 1'b1);
        waitDrain(3 * FRAME * BAUD_FAST, "frame-end write");

`ifdef UART_TX_PARITY_EN
        applyStimulus(8'h07, BAUD_FAST, -1, 1'b1, 1'b1);
        applyStimulus(8'h03, BAUD_FAST, 0, 1'b1, 1'b1);
        waitDrain(3 * FRAME * BAUD_FAST, "parity");
`endif
        checkOutput("frames observed", framesSeen, framesExpected);

        // Reset during data bit 3 discards frame and pending byte
        monEnable = 1'b0;
        applyStimulus(8'h35, BAUD_FAST, -1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        applyStimulus(8'hC3, BAUD_FAST, -1, 1'b1, 1'b0);
        repeat (1943) @(negedge clk);
        checkOutput("tx_dout low in data bit 3", int'(tx_dout), 0);
        checkOutput("tx_rdy low with byte pending", int'(tx_rdy), 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset tx_dout", int'(tx_dout), 1);
        checkOutput("async reset tx_busy", int'(tx_busy), 0);
        checkOutput("async reset tx_rdy", int'(tx_rdy), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        badCount = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_dout !== 1'b1 || tx_busy !== 1'b0 || tx_rdy !== 1'b1) badCount++;
        end
        checkOutput("idle cycles disturbed after reset", badCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
